// File: rtl/commit_monitor.sv
// Run/step/stop execution control for the CPU core, with cycle and retire counters
// and a circular trace of the most recent accepted commits for debug readback.
module commit_monitor #(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_run,
   input  logic             cmd_step,
   input  logic             cmd_stop,
   output logic             global_en,
   input  logic             commit,
   input  logic [31:0]      commit_pc,
   input  logic [31:0]      commit_inst,
   input  logic             commit_halt,
   input  logic             commit_reg_we,
   input  logic [4:0]       commit_reg_wa,
   input  logic [31:0]      commit_reg_wd,
   output logic [1:0]       state,
   output logic             halted,
   output logic [31:0]      cycle_cnt,
   output logic [31:0]      instr_cnt,
   output logic [IDX_W:0]   trace_count,
   input  logic [IDX_W-1:0] trace_rd_idx,
   output logic             trace_rd_valid,
   output logic [31:0]      trace_rd_pc,
   output logic [31:0]      trace_rd_inst,
   output logic             trace_rd_we,
   output logic [4:0]       trace_rd_wa,
   output logic [31:0]      trace_rd_wd
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_STEP   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam int EW = 32 + 32 + 1 + 5 + 32;

   state_t              r_state, w_next;
   logic                r_en_q;
   logic [31:0]         r_cycle_cnt, r_instr_cnt;
   logic [IDX_W:0]      r_trace_cnt;
   logic [IDX_W-1:0]    r_wp;
   logic [EW-1:0]       r_mem [DEPTH];
   logic [EW-1:0]       r_rd;
   logic                r_rd_valid;
   logic                w_acc;
   logic [IDX_W-1:0]    w_slot;

   // The core's commit outputs freeze while disabled; a commit is fresh only if the
   // core was enabled on the edge that produced it.
   assign w_acc     = commit & r_en_q;
   assign global_en = (r_state == S_RUN) || (r_state == S_STEP);
   assign w_slot    = r_wp - IDX_W'(1) - trace_rd_idx;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (cmd_run)       w_next = S_RUN;
            else if (cmd_step) w_next = S_STEP;
         end
         S_RUN: begin
            if (w_acc && commit_halt) w_next = S_HALTED;
            else if (cmd_stop)        w_next = S_IDLE;
         end
         S_STEP: begin
            if (w_acc && commit_halt) w_next = S_HALTED;
            else if (w_acc)           w_next = S_IDLE;
            else if (cmd_stop)        w_next = S_IDLE;
         end
         default: w_next = S_HALTED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_en_q      <= 1'b0;
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
         r_trace_cnt <= '0;
         r_wp        <= '0;
         r_rd        <= '0;
         r_rd_valid  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_en_q  <= global_en;
         if (global_en) r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if (w_acc) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
            r_wp        <= r_wp + IDX_W'(1);
            if (r_trace_cnt < (IDX_W+1)'(DEPTH)) r_trace_cnt <= r_trace_cnt + (IDX_W+1)'(1);
         end
         // Read sees the pre-edge pointer and contents; a same-cycle write shows up next read.
         if ({1'b0, trace_rd_idx} < r_trace_cnt) begin
            r_rd       <= r_mem[w_slot];
            r_rd_valid <= 1'b1;
         end else begin
            r_rd       <= '0;
            r_rd_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_acc)
         r_mem[r_wp] <= {commit_pc, commit_inst, commit_reg_we, commit_reg_wa, commit_reg_wd};
   end

   assign state          = r_state;
   assign halted         = (r_state == S_HALTED);
   assign cycle_cnt      = r_cycle_cnt;
   assign instr_cnt      = r_instr_cnt;
   assign trace_count    = r_trace_cnt;
   assign trace_rd_valid = r_rd_valid;
   assign {trace_rd_pc, trace_rd_inst, trace_rd_we, trace_rd_wa, trace_rd_wd} = r_rd;

endmodule

// File: tb/tb_commit_monitor.sv
// Random command/commit stimulus for commit_monitor, checked every cycle against a
// queue-based reference model; the bench also plays the core holding commits while disabled.
module tb_commit_monitor;
   localparam int DEPTH = 16;
   localparam int IDX_W = 4;

   logic             clk = 1'b0;
   logic             rst, cmd_run, cmd_step, cmd_stop, global_en;
   logic             commit, commit_halt, commit_reg_we;
   logic [31:0]      commit_pc, commit_inst, commit_reg_wd;
   logic [4:0]       commit_reg_wa;
   logic [1:0]       state;
   logic             halted;
   logic [31:0]      cycle_cnt, instr_cnt;
   logic [IDX_W:0]   trace_count;
   logic [IDX_W-1:0] trace_rd_idx;
   logic             trace_rd_valid, trace_rd_we;
   logic [31:0]      trace_rd_pc, trace_rd_inst, trace_rd_wd;
   logic [4:0]       trace_rd_wa;

   always #5 clk = ~clk;

   commit_monitor #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_stop(cmd_stop),
      .global_en(global_en), .commit(commit), .commit_pc(commit_pc), .commit_inst(commit_inst),
      .commit_halt(commit_halt), .commit_reg_we(commit_reg_we), .commit_reg_wa(commit_reg_wa),
      .commit_reg_wd(commit_reg_wd), .state(state), .halted(halted), .cycle_cnt(cycle_cnt),
      .instr_cnt(instr_cnt), .trace_count(trace_count), .trace_rd_idx(trace_rd_idx),
      .trace_rd_valid(trace_rd_valid), .trace_rd_pc(trace_rd_pc), .trace_rd_inst(trace_rd_inst),
      .trace_rd_we(trace_rd_we), .trace_rd_wa(trace_rd_wa), .trace_rd_wd(trace_rd_wd)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
   } tr_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          m_state;
   bit          m_en_q, m_ge;
   logic [31:0] m_cyc, m_instr, m_pc;
   tr_t         m_q[$];
   tr_t         m_rd;
   bit          m_rd_valid;
   int          n_halts = 0, n_wraps = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_en_q = 0; m_cyc = 0; m_instr = 0;
      m_q.delete(); m_rd = '0; m_rd_valid = 0;
   endtask

   // Model of one clock edge, using the inputs that were stable across it.
   task automatic model_edge();
      bit  acc;
      tr_t e;
      m_ge = (m_state == 1) || (m_state == 2);
      acc  = commit && m_en_q;
      if (rst) begin
         model_reset();
         return;
      end
      if (int'(trace_rd_idx) < m_q.size()) begin
         m_rd = m_q[trace_rd_idx]; m_rd_valid = 1;
      end else begin
         m_rd = '0; m_rd_valid = 0;
      end
      if (acc) begin
         e = '{commit_pc, commit_inst, commit_reg_we, commit_reg_wa, commit_reg_wd};
         m_q.push_front(e);
         if (m_q.size() > DEPTH) begin
            void'(m_q.pop_back());
            n_wraps++;
         end
         m_instr++;
      end
      if (m_ge) m_cyc++;
      case (m_state)
         0: if (cmd_run) m_state = 1; else if (cmd_step) m_state = 2;
         1: if (acc && commit_halt) m_state = 3; else if (cmd_stop) m_state = 0;
         2: if (acc && commit_halt) m_state = 3; else if (acc || cmd_stop) m_state = 0;
         default: m_state = 3;
      endcase
      if (m_state == 3 && acc && commit_halt) n_halts++;
      m_en_q = m_ge;
   endtask

   task automatic check_all();
      chk("state", 32'(state), 32'(m_state));
      chk("global_en", 32'(global_en), 32'((m_state == 1) || (m_state == 2)));
      chk("halted", 32'(halted), 32'(m_state == 3));
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("instr_cnt", instr_cnt, m_instr);
      chk("trace_count", 32'(trace_count), 32'(m_q.size()));
      chk("rd_valid", 32'(trace_rd_valid), 32'(m_rd_valid));
      chk("rd_pc", trace_rd_pc, m_rd.pc);
      chk("rd_inst", trace_rd_inst, m_rd.inst);
      chk("rd_we", 32'(trace_rd_we), 32'(m_rd.we));
      chk("rd_wa", 32'(trace_rd_wa), 32'(m_rd.wa));
      chk("rd_wd", trace_rd_wd, m_rd.wd);
   endtask

   // Core behaviour: new commit values appear only after an edge where it was enabled.
   task automatic core_advance();
      commit        = ($urandom_range(0, 3) != 0);
      commit_halt   = commit && ($urandom_range(0, 49) == 0);
      commit_pc     = m_pc;
      commit_inst   = commit_halt ? 32'h0010_0073 : $urandom;
      commit_reg_we = 1'($urandom);
      commit_reg_wa = 5'($urandom);
      commit_reg_wd = $urandom;
      if (commit) m_pc = m_pc + 32'd4;
   endtask

   initial begin
      m_pc = 32'h0040_0000;
      rst = 1; cmd_run = 0; cmd_step = 0; cmd_stop = 0; trace_rd_idx = '0;
      commit = 0; commit_halt = 0; commit_pc = '0; commit_inst = '0;
      commit_reg_we = 0; commit_reg_wa = '0; commit_reg_wd = '0;
      model_reset();
      for (int cyc = 0; cyc < 6000; cyc++) begin
         rst          = (cyc < 10) || ($urandom_range(0, 399) == 0);
         cmd_run      = (cyc >= 10) && ($urandom_range(0, 11) == 0);
         cmd_step     = (cyc >= 10) && ($urandom_range(0, 7) == 0);
         cmd_stop     = (cyc >= 10) && ($urandom_range(0, 29) == 0);
         trace_rd_idx = IDX_W'($urandom);
         @(posedge clk);
         model_edge();
         #1;
         if (m_ge) core_advance();
         @(negedge clk);
         check_all();
      end
      if (n_halts == 0 || n_wraps == 0)
         $display("[TB] note: coverage thin (halts %0d, wraps %0d)", n_halts, n_wraps);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
